// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, default latencies and shared types for the HI/LO multiply/divide unit.
// Shared by the decoder, the hazard unit and mult_div_unit.
package mdu_pkg;

    localparam int unsigned MDU_XLEN        = 32;
    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MADD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [MDU_XLEN-1:0] hi;
        logic [MDU_XLEN-1:0] lo;
    } mdu_res_t;

    function automatic logic [2*MDU_XLEN-1:0] sext64(input logic [MDU_XLEN-1:0] x);
        return {{MDU_XLEN{x[MDU_XLEN-1]}}, x};
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Define MDU_MADD_EN to enable op 7 (MADD: {hi,lo} += signed a*b).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    mdu_res_t           r_sh;
    logic               r_sh_wr;

    mdu_op_e            w_op;
    logic               w_load_sh;
    logic               w_commit;
    logic               w_mthi;
    logic               w_mtlo;
    mdu_res_t           w_res;
    logic               w_res_wr;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_dvs;
    logic [31:0]        w_quo_s;
    logic [31:0]        w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;

    assign w_op = mdu_op_e'(op);

    // 64-bit datapath; divisor forced to 1 on b==0 so no X reaches the shadow regs
    assign w_prod_s = 64'($signed(sext64(a)) * $signed(sext64(b)));
    assign w_prod_u = 64'({32'd0, a} * {32'd0, b});
    assign w_dvs    = (b == 32'd0) ? 32'd1 : b;
    assign w_quo_s  = 32'($signed(sext64(a)) / $signed(sext64(w_dvs)));
    assign w_rem_s  = 32'($signed(sext64(a)) % $signed(sext64(w_dvs)));
    assign w_quo_u  = a / w_dvs;
    assign w_rem_u  = a % w_dvs;

    // Result selection; divide by zero suppresses the final write to HI/LO
    always_comb begin
        w_res    = '0;
        w_res_wr = 1'b1;
        case (w_op)
            MD_MULT:  w_res = w_prod_s;
            MD_MULTU: w_res = w_prod_u;
            MD_DIV: begin
                w_res    = {w_rem_s, w_quo_s};
                w_res_wr = (b != 32'd0);
            end
            MD_DIVU: begin
                w_res    = {w_rem_u, w_quo_u};
                w_res_wr = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
`endif
            default:  w_res = '0;
        endcase
    end

    // Next-state / control decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_sh   = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (w_op)
                        MD_MTHI: w_mthi = 1'b1;
                        MD_MTLO: w_mtlo = 1'b1;
                        MD_MULT, MD_MULTU: begin
                            w_state_nxt = ST_BUSY;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                            w_load_sh   = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_state_nxt = ST_BUSY;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                            w_load_sh   = 1'b1;
                        end
`ifdef MDU_MADD_EN
                        MD_MADD: begin
                            w_state_nxt = ST_BUSY;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                            w_load_sh   = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_BUSY);
        end
    end

    // Shadow capture at accept, HI/LO commit when busy drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh    <= '0;
            r_sh_wr <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_load_sh) begin
                r_sh    <= w_res;
                r_sh_wr <= w_res_wr;
            end
            if (w_commit) begin
                if (r_sh_wr) begin
                    r_hi <= r_sh.hi;
                    r_lo <= r_sh.lo;
                end
            end else begin
                if (w_mthi) r_hi <= a;
                if (w_mtlo) r_lo <= a;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
